// File: rtl/ext_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_defs_pkg
// Description : Shared immediate-extension definitions: mode encodings and
//               default field widths used by decoder, control and extender.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_defs_pkg;

    // Immediate extension modes selected by the decoder
    typedef enum logic [1:0] {
        EXT_MODE_SHAMT = 2'd0,
        EXT_MODE_IMM   = 2'd1,
        EXT_MODE_JMP   = 2'd2,
        EXT_MODE_UPPER = 2'd3
    } ext_mode_e;

    // Default datapath and field widths
    localparam int c_DEF_DATA_W = 32;
    localparam int c_DEF_W0     = 5;
    localparam int c_DEF_W1     = 14;
    localparam int c_DEF_W2     = 24;
    localparam int c_DEF_W3     = 16;

endpackage : ext_defs_pkg
`default_nettype wire

// File: rtl/ext_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : ext_pipe_reg
// Description : One valid/ready register slice. Loads when empty or when the
//               downstream consumes the held word; holds otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_load;

    // Slot frees up when empty or when its word leaves this cycle
    assign w_load   = !r_valid || out_ready;
    // Refuse new words while the pipeline is being cleared
    assign in_ready = w_load && !flush && !reset;

    // Valid/data register: reset clears all, flush clears valid only
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data <= in_data;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule : ext_pipe_reg
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pipe
// Description : Two-stage pipelined immediate extender. S1 captures the masked
//               field and its controls, S2 registers the sign/zero-extended or
//               upper-placed result.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_pipe
    import ext_defs_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int W0     = c_DEF_W0,
    parameter int W1     = c_DEF_W1,
    parameter int W2     = c_DEF_W2,
    parameter int W3     = c_DEF_W3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_signop,
    input  logic [1:0]        in_exsrc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int c_WW    = $clog2(DATA_W + 1);
    localparam int c_S1_W  = DATA_W + 2 + 1 + c_WW;
    localparam int c_UP_SH = DATA_W - W3;

    if (W0 < 1 || W0 > DATA_W || W1 < 1 || W1 > DATA_W ||
        W2 < 1 || W2 > DATA_W || W3 < 1 || W3 > DATA_W) begin : g_bad_param
        $error("imm_ext_pipe: field widths must lie in 1..DATA_W");
    end

    logic [c_WW-1:0]   w_sel_w;
    logic [DATA_W-1:0] w_field;
    logic              w_s1_valid;
    logic [c_S1_W-1:0] w_s1_data;
    logic              w_s2_ready;
    logic [DATA_W-1:0] w_s1_field;
    ext_mode_e         w_s1_mode;
    logic              w_s1_signop;
    logic [c_WW-1:0]   w_s1_w;
    logic              w_sbit;
    logic [DATA_W-1:0] w_ext;

    // Field width chosen by the incoming mode
    always_comb begin
        w_sel_w = c_WW'(W0);
        case (ext_mode_e'(in_exsrc))
            EXT_MODE_SHAMT: w_sel_w = c_WW'(W0);
            EXT_MODE_IMM:   w_sel_w = c_WW'(W1);
            EXT_MODE_JMP:   w_sel_w = c_WW'(W2);
            EXT_MODE_UPPER: w_sel_w = c_WW'(W3);
            default:        w_sel_w = c_WW'(W0);
        endcase
    end

    // Keep only the low field bits, zero above
    always_comb begin
        w_field = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_field[i] = in_data[i] && (i < int'(w_sel_w));
        end
    end

    ext_pipe_reg #(
        .WIDTH (c_S1_W)
    ) u_s1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({w_field, in_exsrc, in_signop, w_sel_w}),
        .out_valid (w_s1_valid),
        .out_ready (w_s2_ready),
        .out_data  (w_s1_data)
    );

    assign w_s1_field  = w_s1_data[c_S1_W-1 -: DATA_W];
    assign w_s1_mode   = ext_mode_e'(w_s1_data[c_WW+2 : c_WW+1]);
    assign w_s1_signop = w_s1_data[c_WW];
    assign w_s1_w      = w_s1_data[c_WW-1:0];

    // Extension: fill above the field with its top bit or zero, or shift up
    always_comb begin
        w_sbit = 1'b0;
        w_ext  = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(w_s1_w) == i + 1) begin
                w_sbit = w_s1_field[i];
            end
        end
        w_sbit = w_sbit && w_s1_signop;
        if (w_s1_mode == EXT_MODE_UPPER) begin
            w_ext = w_s1_field << c_UP_SH;
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                w_ext[i] = (i < int'(w_s1_w)) ? w_s1_field[i] : w_sbit;
            end
        end
    end

    ext_pipe_reg #(
        .WIDTH (DATA_W)
    ) u_s2 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (w_s1_valid),
        .in_ready  (w_s2_ready),
        .in_data   (w_ext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule : imm_ext_pipe
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_ext_pipe
// Description : Self-checking bench for imm_ext_pipe: directed scenarios plus
//               random traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_ext_pipe;

    localparam int DW = 32;
    localparam int W0 = 5;
    localparam int W1 = 14;
    localparam int W2 = 24;
    localparam int W3 = 16;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, in_signop;
    logic          out_valid, out_ready;
    logic [1:0]    in_exsrc;
    logic [DW-1:0] in_data, out_data;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] q[$];

    always #5 clk = ~clk;

    imm_ext_pipe #(
        .DATA_W (DW), .W0 (W0), .W1 (W1), .W2 (W2), .W3 (W3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signop (in_signop),
        .in_exsrc  (in_exsrc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Reference: mask the field, then add the two's-complement offset or shift up
    function automatic logic [DW-1:0] ref_ext(logic [DW-1:0] d, logic s, logic [1:0] m);
        int w;
        longint unsigned f, mask;
        w    = (m == 2'd0) ? W0 : (m == 2'd1) ? W1 : (m == 2'd2) ? W2 : W3;
        mask = (64'd1 << w) - 64'd1;
        f    = {32'd0, d} & mask;
        if (m == 2'd3) return DW'(f << (DW - w));
        if (s && ((f >> (w - 1)) & 64'd1) == 64'd1) f = f + (64'd1 << DW) - (64'd1 << w);
        return DW'(f);
    endfunction

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: scoreboard the handshakes seen before the edge, then advance
    task automatic tick();
        #1;
        if (reset || flush) chk("ready_low_in_clear", 32'(in_ready), '0);
        if (out_valid) begin
            if (q.size() == 0) chk("spurious_out", 32'(out_valid), '0);
            else begin
                chk("sb_data", out_data, q[0]);
                if (out_ready) void'(q.pop_front());
            end
        end
        if (in_valid && in_ready) q.push_back(ref_ext(in_data, in_signop, in_exsrc));
        if (reset || flush) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [DW-1:0] d, logic s, logic [1:0] m);
        in_valid  = 1'b1;
        in_data   = d;
        in_signop = s;
        in_exsrc  = m;
    endtask

    task automatic expect_out(string tag, logic [DW-1:0] e);
        int k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, out_data, e);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_signop = 1'b0; in_exsrc = 2'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", 32'(in_ready), '0);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);

        // Mode 0 signed, two-edge latency
        out_ready = 1'b1;
        send(32'h0000_0010, 1'b1, 2'd0);
        tick();
        in_valid = 1'b0;
        chk("lat_not_yet", 32'(out_valid), '0);
        tick();
        chk("m0_valid", 32'(out_valid), 32'd1);
        chk("m0_signed", out_data, 32'hFFFF_FFF0);

        // Mode 1 unsigned then signed
        send(32'hFFFF_FFFF, 1'b0, 2'd1);
        tick();
        send(32'hFFFF_FFFF, 1'b1, 2'd1);
        tick();
        in_valid = 1'b0;
        expect_out("m1_unsigned", 32'h0000_3FFF);
        tick();
        expect_out("m1_signed", 32'hFFFF_FFFF);
        tick();

        // Mode 2 and mode 3 back to back
        send(32'h0080_0000, 1'b1, 2'd2);
        tick();
        send(32'h1234_ABCD, 1'b1, 2'd3);
        tick();
        in_valid = 1'b0;
        chk("m2_valid", 32'(out_valid), 32'd1);
        chk("m2_jmp", out_data, 32'hFF80_0000);
        tick();
        chk("m3_valid", 32'(out_valid), 32'd1);
        chk("m3_upper", out_data, 32'hABCD_0000);
        tick();

        // Back-pressure: A, B accepted, C blocked until out_ready rises
        out_ready = 1'b0;
        send(32'h0000_0011, 1'b1, 2'd0);
        tick();
        send(32'h0000_2001, 1'b1, 2'd1);
        tick();
        send(32'h0000_0123, 1'b0, 2'd2);
        #1;
        chk("bp_ready_low", 32'(in_ready), '0);
        tick();
        tick();
        chk("bp_hold_a", out_data, 32'hFFFF_FFF1);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        chk("bp_b", out_data, 32'hFFFF_E001);
        tick();
        chk("bp_c_valid", 32'(out_valid), 32'd1);
        chk("bp_c", out_data, 32'h0000_0123);
        tick();
        chk("bp_empty", 32'(out_valid), '0);

        // Flush with both stages full and a word offered
        out_ready = 1'b0;
        send(32'h0000_0001, 1'b0, 2'd0);
        tick();
        send(32'h0000_0002, 1'b0, 2'd0);
        tick();
        send(32'h0000_0003, 1'b0, 2'd0);
        flush = 1'b1;
        #1;
        chk("fl_ready_low", 32'(in_ready), '0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("fl_out_cleared", 32'(out_valid), '0);
        repeat (3) tick();
        chk("fl_nothing_back", 32'(out_valid), '0);
        send(32'h0000_2FFF, 1'b1, 2'd1);
        tick();
        in_valid = 1'b0;
        expect_out("fl_next_word", 32'hFFFF_EFFF);
        tick();

        // Reset mid-stream with two words in flight
        out_ready = 1'b0;
        send(32'h0000_0007, 1'b0, 2'd0);
        tick();
        send(32'h0000_0008, 1'b0, 2'd0);
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("mr_out_valid", 32'(out_valid), '0);
        chk("mr_out_data", out_data, '0);
        reset = 1'b0;
        #1;
        chk("mr_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("mr_nothing_back", 32'(out_valid), '0);

        // Random traffic with occasional flushes
        repeat (400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_signop = 1'($urandom_range(0, 1));
            in_exsrc  = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        begin
            int k = 0;
            while (q.size() > 0 && k < 20) begin
                tick();
                k++;
            end
        end
        chk("drain_empty", 32'(q.size()), '0);
        tick();
        chk("drain_idle", 32'(out_valid), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_imm_ext_pipe
`default_nettype wire

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate extender for the datapath's decode/execute boundary. Each accepted instruction word has an immediate field pulled out according to a 2-bit mode. The field is then sign- or zero-extended to `DATA_W`, or placed into the upper bits (mode 3). The block is two register stages with valid/ready handshaking on both sides, so it can sit between a stalling decoder and the ALU operand mux without losing or duplicating immediates.

## Interface
- `DATA_W`, 32: instruction and result width.
- `W0`, 5: field width for mode 0 (shift amounts, short immediates).
- `W1`, 14: field width for mode 1 (I-type immediate).
- `W2`, 24: field width for mode 2 (jump offset).
- `W3`, 16: field width for mode 3 (upper-immediate placement).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline clear (branch redirect).
- `in_valid`  in  1  upstream offers a word.
- `in_ready`  out  1  block can take a word this cycle.
- `in_data`  in  DATA_W  instruction word; the field is always `in_data[Wm-1:0]`.
- `in_signop`  in  1  1 selects sign extension, 0 selects zero extension (ignored in mode 3).
- `in_exsrc`  in  2  mode select 0..3.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream takes the result.
- `out_data`  out  DATA_W  extended immediate.

Legal parameters: 1 ≤ W0, W1, W2, W3 ≤ DATA_W. Violations are an elaboration error.

## Operation
- A transfer occurs on a port when its valid and ready are both 1 at a rising edge.
- Stage S1 registers `in_data[W-1:0]` zero-padded to `DATA_W`, plus the selected width, `in_signop` and `in_exsrc`, plus `s1_valid`.
- Stage S2 computes and registers the result into `out_data`, plus `out_valid`.
- Modes 0–2 (W = W0/W1/W2):
  - Bits `[W-1:0]` pass through unchanged.
  - Bits `[DATA_W-1:W]` are all `field[W-1]` when signop=1, and all 0 when signop=0.
  - With W = DATA_W, the output equals the field.
- Mode 3: `out_data = field[W3-1:0] << (DATA_W-W3)`; the low bits are 0 and signop is ignored.
- Stall rules:
  - S2 may load when `!out_valid || out_ready`.
  - S1 may advance when `!s1_valid || S2 may load`.
  - `in_ready` is S1's advance condition.
  - This is a combinational ready chain from `out_ready` to `in_ready`; no combinational path exists from `in_valid` to `out_valid`.
- A stalled stage holds all of its registers unchanged.
- Order is strictly preserved; no word is dropped or duplicated.
- `flush`:
  - Clears `s1_valid` and `out_valid` at the edge.
  - A word offered in the same cycle is not accepted (`in_ready` = 0 while `flush` = 1).
  - Data registers are unaffected.
- `reset`: every register becomes 0, so `out_valid`=0, `out_data`=0 and `s1_valid`=0. `in_ready` = 0 while `reset` = 1, and 1 in the first cycle after release.
- Reset or flush mid-stream discards all in-flight words; nothing reappears afterwards.
- Reset and flush together behave as reset.

## Timing
- Latency: a word accepted at edge N appears with `out_valid`=1 after edge N+1, i.e. two edges to the output register, given no stall.
- Throughput: one word per cycle with `out_ready` held at 1.
- Capacity: 2 words (S1 + S2).
  - With `out_ready`=0, the first two words are accepted.
  - `in_ready` then goes to 0 in the cycle after the second acceptance.
  - `in_ready` returns to 1 in the same cycle `out_ready` rises.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Structure
- The shared definitions file `ext_defs` holds the mode encodings: `EXT_MODE_SHAMT`=0, `EXT_MODE_IMM`=1, `EXT_MODE_JMP`=2, `EXT_MODE_UPPER`=3, plus the default field-width constants. Decoder and control unit include the same file.
- Sub-module `ext_pipe_reg`: one valid/ready register slice, parametrised by payload width. It is instantiated twice (S1 payload = DATA_W+2+1+width code; S2 payload = DATA_W).
- The extension logic is a combinational function between the two slices, in the top level.

## Test plan
- Mode 0 signed: `in_data`=0x0000_0010, signop=1, `out_ready`=1 → `out_data`=0xFFFF_FFF0 two edges after acceptance.
- Mode 1 unsigned: `in_data`=0xFFFF_FFFF → 0x0000_3FFF. Same word with signop=1 → 0xFFFF_FFFF.
- Mode 2 and mode 3, back-to-back in consecutive cycles:
  - `in_data`=0x0080_0000, signop=1, mode 2 → 0xFF80_0000.
  - `in_data`=0x1234_ABCD, signop=1, mode 3 → 0xABCD_0000.
  - Both results appear on consecutive cycles.
- Back-pressure: feed A, B, C every cycle with `out_ready`=0 for 4 cycles.
  - `in_ready` falls after B is accepted.
  - Output holds A, stable.
  - After release, the results are A, B, C in order with no gaps.
- Flush: assert `flush` while S1 and S2 both hold valid words → `out_valid`=0 next cycle and neither word is ever output. The next word accepted after `flush` falls arrives normally.
- Reset mid-stream: reset with 2 words in flight → `out_valid`=0 and `out_data`=0 after the edge; `in_ready`=1 in the first cycle after release.
